div_request_adapter: RTL

Front end of the unsigned iterative divider, sitting between the execute stage and the divider core.
- Accepts RISC-V M-extension divide ops (DIV, DIVU, REM, REMU) over a valid/ready handshake.
- Converts signed operands to magnitudes and drives the divider start/ready interface.
- Sign-corrects the divider result and returns the selected result word.
- Resolves divide-by-zero and signed overflow locally without starting the divider.

---
 rtl/div_request_adapter_if.sv | 41 ++++
 rtl/div_request_adapter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_request_adapter_if.sv
// Handshake bundle between the execute stage, div_request_adapter and the divider core.
// Valid/ready: a word moves on a rising clock edge where valid and ready are both high;
// the sender holds valid and its payload steady until then, and ready never waits on valid.
interface div_request_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  op_valid;
    logic                  op_ready;
    logic [1:0]            op_code;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [TAG_WIDTH-1:0]  op_tag;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [TAG_WIDTH-1:0]  res_tag;
    logic                  div_start;
    logic [DATA_WIDTH-1:0] div_numerator;
    logic [DATA_WIDTH-1:0] div_denominator;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic                  div_valid;
    logic                  div_ready_o;
    logic                  div_ready_i;

    // slave is the adapter; master is the execute stage together with the divider core.
    modport slave (
        input  op_valid, op_code, op_a, op_b, op_tag, res_ready,
               div_quotient, div_remainder, div_valid, div_ready_o,
        output op_ready, res_valid, res_data, res_tag,
               div_start, div_numerator, div_denominator, div_ready_i
    );

    modport master (
        output op_valid, op_code, op_a, op_b, op_tag, res_ready,
               div_quotient, div_remainder, div_valid, div_ready_o,
        input  op_ready, res_valid, res_data, res_tag,
               div_start, div_numerator, div_denominator, div_ready_i
    );
endinterface

// File: rtl/div_request_adapter.sv
// RISC-V DIV/DIVU/REM/REMU front end for an unsigned iterative divider: operand magnitudes in,
// sign-corrected quotient or remainder out, divide-by-zero and signed overflow answered locally.
module div_request_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    div_request_adapter_if.slave bus,
    output logic [1:0]           o_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    state_t                r_state;
    logic                  r_op_ready;
    logic                  r_is_rem;
    logic                  r_sa;
    logic                  r_sb;
    logic [DATA_WIDTH-1:0] r_num;
    logic [DATA_WIDTH-1:0] r_den;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [TAG_WIDTH-1:0]  r_res_tag;

    logic                  w_signed;
    logic                  w_sa;
    logic                  w_sb;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;
    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_overflow;
    logic [DATA_WIDTH-1:0] w_fast_res;
    logic [DATA_WIDTH-1:0] w_q;
    logic [DATA_WIDTH-1:0] w_r;

    assign w_signed   = ~bus.op_code[0];
    assign w_sa       = bus.op_a[DATA_WIDTH-1] & w_signed;
    assign w_sb       = bus.op_b[DATA_WIDTH-1] & w_signed;
    // MIN negates to itself, which is already the right unsigned magnitude.
    assign w_mag_a    = w_sa ? -bus.op_a : bus.op_a;
    assign w_mag_b    = w_sb ? -bus.op_b : bus.op_b;
    assign w_accept   = bus.op_valid & r_op_ready;
    assign w_div_zero = (bus.op_b == '0);
    assign w_overflow = w_signed & (bus.op_a == MIN_VAL) & (bus.op_b == ALL_ONES);

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = bus.op_code[1] ? bus.op_a : ALL_ONES;
        end else begin
            w_fast_res = bus.op_code[1] ? '0 : MIN_VAL;
        end
    end

    // Quotient is negative when exactly one operand was; remainder follows the dividend.
    assign w_q = (r_sa ^ r_sb) ? -bus.div_quotient : bus.div_quotient;
    assign w_r = r_sa ? -bus.div_remainder : bus.div_remainder;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b0;
            r_is_rem   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_num      <= '0;
            r_den      <= '0;
            r_res_data <= '0;
            r_res_tag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_ready <= 1'b0;
                        r_is_rem   <= bus.op_code[1];
                        r_sa       <= w_sa;
                        r_sb       <= w_sb;
                        r_num      <= w_mag_a;
                        r_den      <= w_mag_b;
                        r_res_tag  <= bus.op_tag;
                        if (w_div_zero || w_overflow) begin
                            r_res_data <= w_fast_res;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_op_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.div_ready_o) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.div_valid) begin
                        r_res_data <= r_is_rem ? w_r : w_q;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_op_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready        = r_op_ready;
    assign bus.res_valid       = (r_state == S_DONE);
    assign bus.res_data        = r_res_data;
    assign bus.res_tag         = r_res_tag;
    assign bus.div_start       = (r_state == S_ISSUE) & bus.div_ready_o;
    assign bus.div_numerator   = r_num;
    assign bus.div_denominator = r_den;
    assign bus.div_ready_i     = (r_state == S_WAIT);
    assign o_state             = r_state;
endmodule
